// File: rtl/exe_mdu.sv
// exe_mdu: iterative multiply/divide unit for the execute stage (RV32M/RV64M).
// A shift-add multiplier and a restoring divider share one hi/lo accumulator
// pair and retire BITS_PER_CYCLE bits per BUSY cycle. Both work on operand
// magnitudes, and the sign is restored when the result is written.
module exe_mdu #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            res_v_o,
  output logic [XLEN-1:0] res_data_o
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = XLEN / BPC;
  localparam int CW  = $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(N);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);
  localparam logic [XLEN-1:0] ONES     = '1;
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opnd_q;     // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0] hi_q;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q;       // multiplier bits still to consume / dividend->quotient
  logic            neg_q;      // product or quotient must be negated
  logic            rem_neg_q;  // remainder must be negated (dividend sign)
  logic [CW-1:0]   cnt;

  // accept-side decode
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  // iteration datapath
  logic [XLEN+BPC-1:0]   pp, sum;
  logic [2*XLEN+BPC-1:0] cat;
  logic [XLEN:0]         trial;
  logic [XLEN-1:0]       r, q;
  logic [XLEN-1:0]       hi_nxt, lo_nxt;

  // result fix-up
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin_res;

  // Decode signedness, magnitudes and the special divide cases at accept.
  always_comb begin
    is_div   = op_i[2];
    // MUL/MULH/MULHSU: rs1 signed. MUL/MULH: rs2 signed. DIV/REM: both signed.
    a_sgn    = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_sgn    = is_div ? ~op_i[0] : ~op_i[1];
    a_neg    = a_sgn & rs1_data_i[XLEN-1];
    b_neg    = b_sgn & rs2_data_i[XLEN-1];
    a_mag    = a_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
    b_mag    = b_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;
    div_zero = is_div & (rs2_data_i == '0);
    div_ovf  = is_div & ~op_i[0] & (rs1_data_i == SMIN) & (rs2_data_i == ONES);
    spec_res = '0;
    if (div_zero)     spec_res = op_i[1] ? rs1_data_i : ONES;
    else if (div_ovf) spec_res = op_i[1] ? '0 : rs1_data_i;
  end

  // One iteration: BPC multiplier bits shift-added, or BPC restoring-divide steps.
  always_comb begin
    // multiply: add opnd * low multiplier chunk into the high half, then shift right
    pp  = {{BPC{1'b0}}, opnd_q} * {{XLEN{1'b0}}, lo_q[BPC-1:0]};
    sum = {{BPC{1'b0}}, hi_q} + pp;
    cat = {sum, lo_q};
    // divide: shift one dividend bit into the remainder, subtract when it fits
    r     = hi_q;
    q     = lo_q;
    trial = '0;
    for (int i = 0; i < BPC; i++) begin
      trial = {r, q[XLEN-1]};
      q     = {q[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, opnd_q}) begin
        trial = trial - {1'b0, opnd_q};
        q[0]  = 1'b1;
      end
      r = trial[XLEN-1:0];
    end
    if (op_q[2]) begin
      hi_nxt = r;
      lo_nxt = q;
    end else begin
      hi_nxt = cat[2*XLEN+BPC-1:XLEN+BPC];
      lo_nxt = cat[XLEN+BPC-1:BPC];
    end
  end

  // Sign fix-up and result select, taken from the final iteration's output.
  always_comb begin
    prod   = {hi_nxt, lo_nxt};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quo_s  = neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
    rem_s  = rem_neg_q ? (~hi_nxt + 1'b1) : hi_nxt;
    case (op_q)
      3'b000:          fin_res = prod_s[XLEN-1:0];
      3'b100, 3'b101:  fin_res = quo_s;
      3'b110, 3'b111:  fin_res = rem_s;
      default:         fin_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  // Control FSM with registered outputs; kill beats accept, reset beats all.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      cnt        <= '0;
      busy_o     <= 1'b0;
      res_v_o    <= 1'b0;
      res_data_o <= '0;
    end else if (kill_i) begin
      state   <= S_IDLE;
      busy_o  <= 1'b0;
      res_v_o <= 1'b0;
    end else begin
      res_v_o <= 1'b0;
      case (state)
        S_BUSY: begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
          cnt  <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state      <= S_DONE;
            busy_o     <= 1'b0;
            res_v_o    <= 1'b1;
            res_data_o <= fin_res;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE with no start drops to IDLE
          if (start_i) begin
            op_q      <= op_i;
            opnd_q    <= is_div ? b_mag : a_mag;
            hi_q      <= '0;
            lo_q      <= is_div ? a_mag : b_mag;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            cnt       <= CNT_LOAD;
            if (div_zero | div_ovf) begin
              state      <= S_DONE;
              busy_o     <= 1'b0;
              res_v_o    <= 1'b1;
              res_data_o <= spec_res;
            end else begin
              state  <= S_BUSY;
              busy_o <= 1'b1;
            end
          end else begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_mdu.sv
// Directed bench for exe_mdu: radix-2 instance for function, specials, kill
// and reset; radix-16 instance for back-to-back latency.
module tb_exe_mdu;

  logic        clk;
  logic        reset_n;
  logic        start, kill, busy, res_v;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, res_data;
  logic        start4, kill4, busy4, res_v4;
  logic [2:0]  op4;
  logic [31:0] rs1_4, rs2_4, res_data4;

  int n_chk;
  int n_err;

  exe_mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .op_i(op),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .kill_i(kill),
    .busy_o(busy), .res_v_o(res_v), .res_data_o(res_data)
  );

  exe_mdu #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start_i(start4), .op_i(op4),
    .rs1_data_i(rs1_4), .rs2_data_i(rs2_4), .kill_i(kill4),
    .busy_o(busy4), .res_v_o(res_v4), .res_data_o(res_data4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op on the radix-2 unit and check latency, data, busy and hold.
  task automatic run1(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat,
                      input bit noise);
    int          cyc;
    bit          busy_seen;
    bit          changed;
    logic [31:0] prev;
    prev = res_data;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    cyc = 0; busy_seen = 0; changed = 0;
    do begin
      @(posedge clk); #1; cyc++;
      start = noise && (cyc == 5 || cyc == 12);
      if (start) begin
        op = 3'b101; rs1 = $urandom; rs2 = 32'd3;
      end
      if (busy) busy_seen = 1;
      if (!res_v && res_data !== prev) changed = 1;
    end while (!res_v && cyc < 100);
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " data"}, res_data, exp);
    chk({tag, " busy"}, busy_seen, lat > 1);
    chk({tag, " hold"}, changed, 0);
    @(posedge clk); #1;
    chk({tag, " pulse"}, res_v, 0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    reset_n = 1'b0;
    start = 0; kill = 0; op = '0; rs1 = '0; rs2 = '0;
    start4 = 0; kill4 = 0; op4 = '0; rs1_4 = '0; rs2_4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset res_v", res_v, 0);
    chk("reset data", res_data, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // multiply
    run1("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
    run1("MULH min*min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
    run1("MULHSU -1*max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
    run1("MULHU max*max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
    // divide
    run1("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
    run1("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
    run1("DIVU 100/7",    3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0);
    run1("REMU 100/7",    3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0);
    run1("REM 7/-2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 1'b0);
    // special cases
    run1("DIVU 5/0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
    run1("REM 5/0",       3'b110, 32'd5,        32'd0,        32'd5,        1,  1'b0);
    run1("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
    run1("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b0);
    // start pulses during BUSY are ignored
    run1("MUL noise",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1);

    // kill at BUSY cycle 10
    op = 3'b000; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("kill pre busy", busy, 1);
    kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (res_v || busy) seen = 1;
    end
    chk("kill no result", seen, 0);

    // start with kill in the same cycle is not accepted (special case would pulse at once)
    op = 3'b101; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b0;
    chk("start+kill res_v", res_v, 0);
    op = 3'b101; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b0;
    chk("start+kill busy", busy, 0);

    // reset mid-operation
    op = 3'b101; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy", busy, 0);
    chk("midrst res_v", res_v, 0);
    chk("midrst data", res_data, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back on the radix-16 unit
    op4 = 3'b000; rs1_4 = 32'd3; rs2_4 = 32'd5; start4 = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      start4 = 1'b0;
    end while (!res_v4 && cyc < 50);
    chk("b2b MUL latency", cyc, 9);
    chk("b2b MUL data", res_data4, 32'd15);
    op4 = 3'b101; rs1_4 = 32'd15; rs2_4 = 32'd4; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    chk("b2b no bubble", busy4, 1);
    cyc = 1;
    while (!res_v4 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("b2b DIVU latency", cyc, 9);
    chk("b2b DIVU data", res_data4, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/exe_mdu.md
# exe_mdu

Parametrised iterative multiply/divide unit for the execute stage, implementing the eight RV32M/RV64M operations. It is started by exe when decode issues an M-extension operation. It raises `busy_o` so the pipeline holds, and returns one result with a single-cycle valid pulse. Width and radix (bits retired per cycle) are parameters. A flush input aborts an operation in flight.

## Interface
- `XLEN`, default 32: operand/result width; must be ≥ 8 and a multiple of `BITS_PER_CYCLE`.
- `BITS_PER_CYCLE`, default 1: quotient/multiplier bits processed per BUSY cycle; power of 2, ≤ 8.
- `clk` in 1: clock; the block uses a single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start_i` in 1: request a new operation; sampled only in IDLE or DONE.
- `op_i` in 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data_i` in XLEN: dividend / multiplicand; sampled with `start_i`.
- `rs2_data_i` in XLEN: divisor / multiplier; sampled with `start_i`.
- `kill_i` in 1: flush; aborts any operation, including one being started in the same cycle.
- `busy_o` out 1: registered; 1 while state is BUSY.
- `res_v_o` out 1: registered; 1 for exactly one cycle, in DONE.
- `res_data_o` out XLEN: result; valid when `res_v_o`=1, holds its value until the next DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Reset (`reset_n`=0 at a clk edge), from any state:
  - state goes to IDLE; `busy_o`=0, `res_v_o`=0, `res_data_o`=0;
  - all internal accumulators and the counter clear.
- Accept condition: state ∈ {IDLE, DONE} & `start_i` & ~`kill_i`.
  - Latches op, operand magnitudes, and sign flags.
  - Loads the iteration counter with N = XLEN/BITS_PER_CYCLE.
  - Next state is BUSY, or DONE for the special cases below.
- `start_i` while in BUSY is ignored. Decode must hold the instruction while `busy_o`=1.
- `kill_i`=1 in any state: next state is IDLE and no `res_v_o` pulse is produced. Kill has priority over accept.
- Multiply:
  - unsigned shift-add on magnitudes into a 2·XLEN product, BITS_PER_CYCLE multiplier bits per cycle;
  - operand signedness: MUL/MULH treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned;
  - the product is negated (two's complement, 2·XLEN wide) iff the effective signs differ;
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - restoring division on magnitudes, BITS_PER_CYCLE quotient bits per cycle;
  - DIV/REM use signed operands; DIVU/REMU use unsigned operands;
  - quotient is negative iff the operand signs differ (and the divisor ≠ 0);
  - remainder takes the sign of the dividend.
- Special cases, detected at accept; these skip BUSY and go directly to DONE:
  - divisor = 0: DIV/DIVU return all ones; REM/REMU return rs1.
  - signed overflow (DIV/REM with rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones): DIV returns rs1; REM returns 0.
- In BUSY the counter decrements each cycle. When the counter reaches 1, next state is DONE.
- Sign fix-up and the result mux are applied on the BUSY→DONE transition; `res_data_o` is registered.
- DONE lasts one cycle: next state is BUSY/DONE on accept, otherwise IDLE.

## Timing
- Accept at cycle T:
  - normal operation: BUSY during T+1 … T+N; `res_v_o`=1 at T+N+1;
  - special case: `res_v_o`=1 at T+1.
- Latency for XLEN=32: BITS_PER_CYCLE=1 gives 33 cycles; BITS_PER_CYCLE=4 gives 9 cycles.
- Back-to-back: an accept in DONE at T+N+1 gives BUSY from T+N+2; there is no idle bubble.
- `busy_o` is not asserted in the accept cycle itself. Exe combines `start_i` with `busy_o` to produce its stall.
- `kill_i` at cycle K during BUSY: state is IDLE at K+1 and `res_v_o` is never asserted for that operation.
- Reset asserted mid-operation: all outputs are at their reset values on the next cycle.
- `res_data_o` does not change in IDLE or BUSY.

## Test plan
- MUL: 7 × 0xFFFFFFFD (-3), XLEN=32, BITS_PER_CYCLE=1 -> `res_v_o` 33 cycles after accept, `res_data_o`=0xFFFFFFEB. Repeat with MULH on 0x80000000 × 0x80000000 -> 0x40000000.
- MULHSU: 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULHU on the same operands -> 0xFFFFFFFE.
- Signed divide: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14, REMU -> 2.
- Special cases, each giving `res_v_o` at T+1 with `busy_o` never set:
  - DIVU 5 / 0 -> 0xFFFFFFFF;
  - REM 5 / 0 -> 5;
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Kill, reset, and busy handling:
  - `kill_i` at BUSY cycle 10 -> IDLE next cycle and no `res_v_o`;
  - `start_i`+`kill_i` in the same cycle -> not accepted;
  - `reset_n`=0 mid-operation -> all outputs 0 next cycle;
  - `start_i` pulses during BUSY -> ignored.
- Back-to-back with BITS_PER_CYCLE=4: MUL 3×5 then accept DIVU 15/4 in the DONE cycle -> 15 at T+9, then 3 exactly 9 cycles later.
